keypad_scan_ctrl: RTL
=====================

Name: keypad_scan_ctrl

Overview:
- Write-side sequencer for the 32-deep, 4-bit key-code FIFO.
- Scans a 4x4 matrix keypad one row at a time and debounces press and release.
- Encodes each accepted press as a 4-bit code and issues exactly one write strobe per press.
- Honours the FIFO full flag by stalling rather than dropping the code.

Parameters:
- SCAN_DIV, 16: clocks each row is driven before its columns are sampled; minimum 4.
- DEBOUNCE_CYCLES, 256: consecutive stable cycles needed to accept a press or a release; minimum 2.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- col  in  4  raw keypad column lines, active-high, asynchronous to clock.
- full  in  1  FIFO full flag.
- row  out  4  one-hot row drive, active-high.
- data  out  4  key code presented to the FIFO data input.
- wr_enable  out  1  FIFO write strobe, one cycle per accepted key.
- busy  out  1  high in any state other than SCAN.

Behaviour:
- Clocking/reset: one clock; reset is asynchronous and active-high.
- Reset values: row=4'b0001, data=0, wr_enable=0, busy=0, state=SCAN, all counters 0.
- Column sync: col passes through a 2-flop synchronizer. All decisions use the synchronized value (scol).
- SCAN:
  - Drive row index r (0..3). A dwell counter counts 0..SCAN_DIV-1.
  - On the last dwell cycle, if scol==0: advance r modulo 4 (3 wraps to 0) and clear the dwell counter.
  - If scol!=0: latch r and c, where c is the lowest-indexed set bit of scol. Then enter DEBOUNCE and keep row held.
  - Multiple keys in the same row resolve to the lowest column. Keys in other rows are not seen until a later scan.
- DEBOUNCE:
  - Counter increments each cycle scol[c]==1.
  - Any cycle with scol[c]==0 clears the counter and returns to SCAN at row r+1.
  - When the counter reaches DEBOUNCE_CYCLES-1 with scol[c] still 1, go to EMIT.
- EMIT:
  - data={r[1:0],c[1:0]}, i.e. code = 4*r + c.
  - wr_enable=1 for exactly one cycle, the first EMIT cycle with full==0. Then go to RELEASE.
  - While full==1, stay in EMIT with wr_enable=0 and data held. Key release does not abort the write.
- RELEASE:
  - Row held. Counter increments each cycle scol[c]==0; any scol[c]==1 clears it.
  - At DEBOUNCE_CYCLES-1, go to SCAN at row r+1.
  - A held key therefore never produces a second write.
- data holds its last value outside EMIT. wr_enable is 0 in every state except the single EMIT strike.
- Reset mid-operation (any state) aborts immediately. A pending EMIT code is discarded and no write is issued.
- Throughput: at most one write per press/release pair.
- Press-to-write latency when not full: 2 (sync) + up to 4*SCAN_DIV + DEBOUNCE_CYCLES + 1 clocks.
- All counters are sized with $clog2 of their limits and never wrap past their limits.

Decomposition:
- Package keypad_pkg:
  - State enum {SCAN, DEBOUNCE, EMIT, RELEASE}.
  - Constants KEY_W=4, ROWS=4, COLS=4, FIFO_DEPTH=32.
  - Function encode_key(row_idx, col_idx).
- One natural sub-module, keypad_debounce:
  - Parameterized stable-level counter.
  - Inputs: level, target polarity, clear.
  - Output: a done pulse.
  - Instantiated once and reused for both press and release, with target polarity selected by state.

Test Plan (SCAN_DIV=4, DEBOUNCE_CYCLES=8):
- Clean press of key at row 2, col 1, held 100 cycles then released -> exactly one wr_enable with data=4'h9; busy returns to 0 after release debounce.
- Bouncy press, col[1] toggling every 3 cycles for 30 cycles then stable -> no write during bounce; a single write of data=4'h9 after 8 stable cycles.
- full=1 held for 50 cycles during EMIT of key row 0, col 3 -> wr_enable stays 0 and data=4'h3 held; one write in the first cycle after full drops.
- Two keys in row 3, cols 0 and 2, pressed together -> single write data=4'hC; none for col 2 while held.
- reset asserted during DEBOUNCE, then released -> row=4'b0001, busy=0, no write issued; next press encodes normally.
- No keys pressed for 64 cycles -> row cycles 0001, 0010, 0100, 1000, 0001, each for 4 cycles; wr_enable never asserted.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad scan controller: FSM states,
// matrix geometry and the key-code encoding.
package keypad_pkg;

  localparam int KEY_W      = 4;
  localparam int ROWS       = 4;
  localparam int COLS       = 4;
  localparam int FIFO_DEPTH = 32;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    EMIT,
    RELEASE
  } state_t;

  // Key code is row-major: 4*row + col.
  function automatic logic [KEY_W-1:0] encode_key(input logic [1:0] row_idx,
                                                  input logic [1:0] col_idx);
    return {row_idx, col_idx};
  endfunction

  // Several keys in one row resolve to the lowest-indexed column.
  function automatic logic [1:0] lowest_col(input logic [COLS-1:0] cols);
    logic [1:0] idx;
    logic       found;
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < COLS; i++) begin
      if (cols[i] && !found) begin
        idx   = 2'(i);
        found = 1'b1;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Stable-level counter: pulses done once the level has matched the target
// polarity for CYCLES consecutive clocks.
module keypad_debounce #(
  parameter int CYCLES = 256
) (
  input  logic clock,
  input  logic reset,
  input  logic level,
  input  logic target,
  input  logic clear,
  output logic done
);

  localparam int CNT_W = (CYCLES > 2) ? $clog2(CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CYCLES - 1);

  logic [CNT_W-1:0] count;
  logic             match;

  always_comb begin
    match = (level == target) && !clear;
    done  = match && (count == LAST);
  end

  // Counter restarts on done so it never runs past LAST.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (!match || done) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 matrix keypad scanner feeding a key-code FIFO: row scan, press and
// release debounce, one write strobe per press with stall on FIFO full.
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 16,
  parameter int DEBOUNCE_CYCLES = 256
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [COLS-1:0]  col,
  input  logic             full,
  output logic [ROWS-1:0]  row,
  output logic [KEY_W-1:0] data,
  output logic             wr_enable,
  output logic             busy
);

  localparam int DWELL_W = $clog2(SCAN_DIV);
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_DIV - 1);

  logic [COLS-1:0]    col_meta;
  logic [COLS-1:0]    scol;

  state_t             state;
  state_t             state_next;
  logic [1:0]         row_idx;
  logic [1:0]         row_idx_next;
  logic [1:0]         col_idx;
  logic [1:0]         col_idx_next;
  logic [DWELL_W-1:0] dwell;
  logic [DWELL_W-1:0] dwell_next;
  logic [KEY_W-1:0]   data_next;

  logic               deb_level;
  logic               deb_target;
  logic               deb_clear;
  logic               deb_done;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      col_meta <= '0;
      scol     <= '0;
    end else begin
      col_meta <= col;
      scol     <= col_meta;
    end
  end

  // One counter serves both press (target 1) and release (target 0).
  keypad_debounce #(
    .CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clock  (clock),
    .reset  (reset),
    .level  (deb_level),
    .target (deb_target),
    .clear  (deb_clear),
    .done   (deb_done)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= SCAN;
      row_idx <= '0;
      col_idx <= '0;
      dwell   <= '0;
      data    <= '0;
    end else begin
      state   <= state_next;
      row_idx <= row_idx_next;
      col_idx <= col_idx_next;
      dwell   <= dwell_next;
      data    <= data_next;
    end
  end

  always_comb begin
    state_next   = state;
    row_idx_next = row_idx;
    col_idx_next = col_idx;
    dwell_next   = dwell;
    data_next    = data;
    wr_enable    = 1'b0;
    deb_level    = scol[col_idx];
    deb_target   = 1'b1;
    deb_clear    = 1'b1;

    unique case (state)
      SCAN: begin
        if (dwell == DWELL_LAST) begin
          dwell_next = '0;
          if (scol == '0) begin
            row_idx_next = row_idx + 1'b1;
          end else begin
            col_idx_next = lowest_col(scol);
            state_next   = DEBOUNCE;
          end
        end else begin
          dwell_next = dwell + 1'b1;
        end
      end

      DEBOUNCE: begin
        deb_clear = 1'b0;
        if (!deb_level) begin
          state_next   = SCAN;
          row_idx_next = row_idx + 1'b1;
        end else if (deb_done) begin
          state_next = EMIT;
          data_next  = encode_key(row_idx, col_idx);
        end
      end

      // Strike is the first non-full EMIT cycle; release cannot cancel it.
      EMIT: begin
        if (!full) begin
          wr_enable  = 1'b1;
          state_next = RELEASE;
        end
      end

      RELEASE: begin
        deb_clear  = 1'b0;
        deb_target = 1'b0;
        if (deb_done) begin
          state_next   = SCAN;
          row_idx_next = row_idx + 1'b1;
        end
      end

      default: state_next = SCAN;
    endcase
  end

  always_comb begin
    row  = ROWS'(1) << row_idx;
    busy = (state != SCAN);
  end

endmodule
